// File: rtl/count_event_queue.sv
// Counter sample classifier feeding a small event FIFO with overflow accounting.
// Optional build macro COUNT_EVENT_TICK_FILTER_EN suppresses enqueue of TICK events.
module count_event_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_valid,
  input  logic [3:0] cnt,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_code,
  output logic [3:0] ev_value,
  output logic [4:0] ev_level,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    EvTick     = 2'd0,
    EvHalfway  = 2'd1,
    EvRollover = 2'd2,
    EvSeqErr   = 2'd3
  } ev_code_e;

  logic [3:0]      prev_q;
  logic            have_prev_q;
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [4:0]      level_q;
  logic            overflow_q;
  logic [7:0]      drop_cnt_q;
  logic [5:0]      mem_q [DEPTH];

  logic [3:0] prev_inc;
  ev_code_e   cls;
  logic       push_req, full, pop, push, drop;

  assign prev_inc = prev_q + 4'd1;

  always_comb begin
    cls = EvTick;
    if (have_prev_q && (cnt != prev_inc)) begin
      cls = EvSeqErr;
    end else if (have_prev_q && (prev_q == 4'd15) && (cnt == 4'd0)) begin
      cls = EvRollover;
    end else if (cnt == 4'd8) begin
      cls = EvHalfway;
    end
  end

`ifdef COUNT_EVENT_TICK_FILTER_EN
  // Filtered ticks never reach the FIFO, so they can never count as drops.
  assign push_req = cnt_valid && (cls != EvTick);
`else
  assign push_req = cnt_valid;
`endif

  assign full = (level_q == 5'(DEPTH));
  assign pop  = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= 4'd0;
      have_prev_q <= 1'b0;
    end else if (cnt_valid) begin
      prev_q      <= cnt;
      have_prev_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      level_q <= 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 6'd0;
      end
    end else begin
      if (push) begin
        mem_q[wptr_q] <= {cls, cnt};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 5'd1;
      end else if (pop && !push) begin
        level_q <= level_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hff) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Head fields read as zero when empty so reset/idle outputs are clean.
  assign ev_valid = (level_q != 5'd0);
  assign ev_code  = ev_valid ? mem_q[rptr_q][5:4] : 2'd0;
  assign ev_value = ev_valid ? mem_q[rptr_q][3:0] : 4'd0;
  assign ev_level = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_count_event_queue.sv
// Directed bench for count_event_queue with a reference model and an expected-event queue.
module tb_count_event_queue;

  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       cnt_valid;
  logic [3:0] cnt;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_code;
  logic [3:0] ev_value;
  logic [4:0] ev_level;
  logic       overflow;
  logic [7:0] drop_cnt;

  count_event_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_valid(cnt_valid),
    .cnt      (cnt),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_value (ev_value),
    .ev_level (ev_level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [5:0] sb[$];
  logic       m_have;
  logic [3:0] m_prev;
  logic       m_ovf;
  int         m_drops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] classify(input logic [3:0] c);
    logic [3:0] nxt;
    nxt = m_prev + 4'd1;
    if (m_have && c != nxt) return 2'd3;
    if (m_have && m_prev == 4'd15 && c == 4'd0) return 2'd2;
    if (c == 4'd8) return 2'd1;
    return 2'd0;
  endfunction

  // One clock cycle: drive, compare head against the scoreboard, advance the model.
  task automatic step(input logic v, input logic [3:0] c, input logic rdy);
    logic [1:0] code;
    logic       full, popping, enq;
    cnt_valid = v;
    cnt       = c;
    ev_ready  = rdy;
    #1;
    check("ev_valid", 32'(ev_valid), 32'(sb.size() != 0));
    check("ev_level", 32'(ev_level), 32'(sb.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    if (sb.size() != 0) begin
      check("head_code", 32'(ev_code), 32'(sb[0][5:4]));
      check("head_value", 32'(ev_value), 32'(sb[0][3:0]));
    end
    full    = (sb.size() == DEPTH);
    popping = rdy && (sb.size() != 0);
    if (popping) void'(sb.pop_front());
    if (v) begin
      code = classify(c);
      enq  = 1'b1;
`ifdef COUNT_EVENT_TICK_FILTER_EN
      if (code == 2'd0) enq = 1'b0;
`endif
      if (enq) begin
        if (!full || popping) begin
          sb.push_back({code, c});
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      m_have = 1'b1;
      m_prev = c;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n     = 1'b0;
    cnt_valid = 1'b0;
    ev_ready  = 1'b0;
    #1;
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_ev_level", 32'(ev_level), 32'd0);
    check("rst_ev_code", 32'(ev_code), 32'd0);
    check("rst_ev_value", 32'(ev_value), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    sb.delete();
    m_have  = 1'b0;
    m_prev  = 4'd0;
    m_ovf   = 1'b0;
    m_drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && sb.size() != 0; i++) step(1'b0, 4'd0, 1'b1);
    #1;
    check("drain_level", 32'(ev_level), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cnt_valid = 1'b0;
    cnt       = 4'd0;
    ev_ready  = 1'b0;
    #2;
    pulse_reset();

    // Full count cycle with a ready consumer.
    for (int i = 1; i <= 16; i++) step(1'b1, 4'(i), 1'b1);
    drain();
    check("seq_overflow", 32'(overflow), 32'd0);

    // Stalled consumer, six pushes into four slots.
    pulse_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 1'b0);
`ifndef COUNT_EVENT_TICK_FILTER_EN
    #1;
    check("ovf_level", 32'(ev_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd2);
    check("ovf_head", 32'(ev_value), 32'd0);
`endif
    drain();
    check("ovf_sticky", 32'(overflow), 32'(m_ovf));

    // Sequence error then recovery.
    pulse_reset();
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    step(1'b1, 4'd10, 1'b0);
    drain();

    // Full FIFO with simultaneous push and pop.
    pulse_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i * 3), 1'b0);
    step(1'b1, 4'd5, 1'b1);
    #1;
    check("pp_level", 32'(ev_level), 32'(sb.size()));
    check("pp_drops", 32'(drop_cnt), 32'd0);
    drain();

    // Reset with events in flight, then a zero sample.
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(13 + i), 1'b0);
    pulse_reset();
    step(1'b1, 4'd0, 1'b0);
`ifndef COUNT_EVENT_TICK_FILTER_EN
    #1;
    check("post_rst_valid", 32'(ev_valid), 32'd1);
    check("post_rst_code", 32'(ev_code), 32'd0);
`endif
    drain();

`ifdef COUNT_EVENT_TICK_FILTER_EN
    pulse_reset();
    for (int i = 6; i <= 9; i++) step(1'b1, 4'(i), 1'b0);
    #1;
    check("filt_level", 32'(ev_level), 32'd1);
    check("filt_code", 32'(ev_code), 32'd1);
    check("filt_value", 32'(ev_value), 32'd8);
    check("filt_drops", 32'(drop_cnt), 32'd0);
    drain();
`endif

    // Repeated value keeps raising SEQ_ERR; drop counter must saturate.
    pulse_reset();
    for (int i = 0; i < 262; i++) step(1'b1, 4'd5, 1'b0);
    #1;
    check("sat_drops", 32'(drop_cnt), 32'd255);
    drain();
    check("sat_hold", 32'(drop_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_event_queue.md
COUNT_EVENT_QUEUE -- requirements
Module: count_event_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, event FIFO entries (power of two, 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cnt_valid  input  1  upstream counter sample strobe, one sample per asserted cycle.
REQ-005 SHALL have port: cnt  input  4  upstream counter value.
REQ-006 SHALL have port: ev_valid  output  1  event available at FIFO head.
REQ-007 SHALL have port: ev_ready  input  1  consumer accepts head event.
REQ-008 SHALL have port: ev_code  output  2  head event class: 0 TICK, 1 HALFWAY, 2 ROLLOVER, 3 SEQ_ERR.
REQ-009 SHALL have port: ev_value  output  4  cnt sample that produced the head event.
REQ-010 SHALL have port: ev_level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port: overflow  output  1  sticky flag, set when an event is dropped.
REQ-012 SHALL have port: drop_cnt  output  8  count of dropped events, saturating at 255.

Function
REQ-013 SHALL register each cnt when cnt_valid=1 as prev, with a have_prev bit set on first sample.
REQ-014 SHALL classify each sample by priority: SEQ_ERR if have_prev and cnt != prev+1 mod 16; else ROLLOVER if have_prev, prev=15, cnt=0; else HALFWAY if cnt=8; else TICK.
REQ-015 SHALL never produce SEQ_ERR or ROLLOVER for the first sample after reset.
REQ-016 SHALL enqueue the classified event {code, cnt} in the same cycle cnt_valid=1 is sampled.
REQ-017 SHALL present an event enqueued into an empty FIFO on ev_valid/ev_code/ev_value at the next cycle (latency 1).
REQ-018 SHALL pop the head when ev_valid=1 and ev_ready=1 at a rising edge; ev_ready ignored when ev_valid=0.
REQ-019 SHALL keep ev_code/ev_value stable while ev_valid=1 and ev_ready=0.
REQ-020 SHALL, on push while full and no pop, drop the new event, set overflow, increment drop_cnt (saturating).
REQ-021 SHALL, on simultaneous push and pop while full, accept the push with no drop; ev_level unchanged.
REQ-022 SHALL, on simultaneous push and pop while non-full/non-empty, keep ev_level unchanged and preserve FIFO order.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; prev arithmetic wraps modulo 16.
REQ-024 SHALL deliver events in strict arrival order; never duplicate or reorder.

Reset
REQ-025 SHALL, while rst_n=0, force ev_valid=0, ev_code=0, ev_value=0, ev_level=0, overflow=0, drop_cnt=0, have_prev=0, prev=0, pointers=0.
REQ-026 SHALL discard all queued events when reset asserts mid-operation; first sample after deassertion treated per REQ-015.
REQ-027 SHALL clear overflow and drop_cnt only by reset.

Configuration
REQ-028 SHALL, with macro COUNT_EVENT_TICK_FILTER_EN defined, classify as usual but never enqueue TICK events (prev still updates; filtered ticks are not drops).
REQ-029 SHALL, without COUNT_EVENT_TICK_FILTER_EN, enqueue every classified event including TICK.

Verification
REQ-030 SHALL cover: reset, then cnt 1..15,0 one per cycle with ev_ready=1 -> 16 events in order, code 1 at value 8, code 2 at value 0, all others 0, no overflow.
REQ-031 SHALL cover: ev_ready=0, push 6 samples with DEPTH=4 -> ev_level=4, overflow=1, drop_cnt=2, head value is first sample.
REQ-032 SHALL cover: cnt 3,4,9 -> third event code 3 value 9; next sample 10 -> code 0.
REQ-033 SHALL cover: FIFO full, push and pop same cycle -> ev_level stays 4, drop_cnt unchanged, new event appears last.
REQ-034 SHALL cover: rst_n pulsed low with 3 queued events -> ev_valid=0, ev_level=0 immediately; next sample 0 -> code 0, not ROLLOVER.
REQ-035 SHALL cover: with COUNT_EVENT_TICK_FILTER_EN, cnt 6..9 -> single event code 1 value 8, drop_cnt=0.
